fifo_basic: RTL and testbench



---
 rtl/fifo_basic_pkg.sv | 17 +
 rtl/fifo_basic_if.sv | 28 ++
 rtl/fifo_basic_mem.sv | 41 ++++
 rtl/fifo_basic.sv | 76 +++++++
 tb/tb_fifo_basic.sv | 119 +++++++++++
 5 files changed

// File: rtl/fifo_basic_pkg.sv
// fifo_basic_pkg: shared defaults for the basic synchronous FIFO.
//   FIFO_DATA_WIDTH : default word width
//   FIFO_DEPTH      : default number of entries (power of two, >= 2)
//   fifo_cnt_width  : width of an occupancy counter that can hold 0..depth
package fifo_basic_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  // Occupancy spans 0..depth inclusive, so one bit wider than the pointers.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FIFO_CNT_W = fifo_cnt_width(FIFO_DEPTH);

endpackage

// File: rtl/fifo_basic_if.sv
// fifo_basic_if: producer/consumer-side bundle of the basic FIFO.
//   enable, write, data_in, read : requests from the user side
//   data_out, empty, full        : registered data and status from the FIFO
//   master modport: user logic driving the FIFO
//   slave  modport: the FIFO itself
interface fifo_basic_if
  import fifo_basic_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);
  logic                  enable;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;

  modport master (
    output enable, write, data_in, read,
    input  data_out, empty, full
  );

  modport slave (
    input  enable, write, data_in, read,
    output data_out, empty, full
  );
endinterface

// File: rtl/fifo_basic_mem.sv
// fifo_basic_mem: DEPTH x DATA_WIDTH register array.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears read register only)
//   we_i    : write strobe, waddr_i/wdata_i written on the rising edge
//   re_i    : read strobe, mem[raddr_i] captured into rdata_o on the edge
//   rdata_o : registered read data, holds when re_i is low
module fifo_basic_mem
  import fifo_basic_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0]            rdata_q;

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read sees the pre-edge contents, so a same-address write in the same
  // cycle (full FIFO, read+write) returns the old head.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_basic.sv
// fifo_basic: single-clock FIFO with registered read data.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : slave side of fifo_basic_if
//            enable gates all activity; write pushes data_in; read pops
//            the oldest word into data_out (one-cycle latency);
//            empty/full decode the registered occupancy count.
module fifo_basic
  import fifo_basic_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_W      = fifo_cnt_width(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  fifo_basic_if.slave  bus
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  empty, full;
  logic                  rd_acc, wr_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A read while full frees the slot the concurrent write lands in.
  assign rd_acc = bus.enable & bus.read & ~empty;
  assign wr_acc = bus.enable & bus.write & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_basic_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (rd_acc & ~rst),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.data_out)
  );

  assign bus.empty = empty;
  assign bus.full  = full;

endmodule

// File: tb/tb_fifo_basic.sv
// tb_fifo_basic: directed + randomized check of fifo_basic against a
// queue-based model of the FIFO's observable behaviour.
module tb_fifo_basic;
  import fifo_basic_pkg::*;

  localparam int DW = FIFO_DATA_WIDTH;
  localparam int DP = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_basic_if #(.DATA_WIDTH(DW)) bus();

  fifo_basic #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Model state: queue of stored words and the expected data_out.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance model on the edge, compare just after.
  task automatic cyc(input logic r, input logic en, input logic wr,
                     input logic rd, input logic [DW-1:0] din);
    bit rd_ok, wr_ok;
    rst         = r;
    bus.enable  = en;
    bus.write   = wr;
    bus.read    = rd;
    bus.data_in = din;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_dout = '0;
    end else if (en) begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = wr && ((mq.size() < DP) || rd_ok);
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(din);
    end
    #1;
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("full",     32'(bus.full),     32'(mq.size() == DP));
  endtask

  initial begin
    bus.enable  = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = '0;

    // Reset held with enable high.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("rst_dout_zero", 32'(bus.data_out), 32'h0);

    // Fill 0x00..0x07, then overflow attempt with 0xAA.
    for (int i = 0; i < DP; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, DW'(i));
    chk("full_after_fill", 32'(bus.full), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < DP; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
      chk("drain_order", 32'(bus.data_out), 32'(i));
    end
    // Underflow read leaves data_out at 0x07.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("underflow_hold", 32'(bus.data_out), 32'h07);

    // Full, then simultaneous read+write across the wrap.
    for (int i = 0; i < DP; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, DW'(8'h10 + i));
    chk("full_after_rw", 32'(bus.full), 32'h1);

    // enable low: nothing moves, 0x55 never enters.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < DP; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("wrap_last", 32'(bus.data_out), 32'h13);

    // Empty with read+write: only the write happens.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);

    // Mid-operation reset discards contents.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, DW'(8'h20 + i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("post_rst_read", 32'(bus.data_out), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h33);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("post_rst_33", 32'(bus.data_out), 32'h33);

    // Randomized traffic with occasional enable-low and rare reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(99) == 0),
          ($urandom_range(9) != 0),
          ($urandom_range(99) < 55),
          ($urandom_range(99) < 45),
          DW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
